// File: rtl/saxo_capture_ctl.sv
// Saxo capture controller: decimates probe_sync, optional masked trigger (CAPTURE_TRIGGER_EN), writes runs to FX2 FIFO4 ending in one PKTEND.
// Latency: a sample taken on a divider tick appears on fifo_wr/fifo_dataout one cycle later; all outputs registered.
// Backpressure: fifo_ready low drops the sample (sticky overflow, saturating drop_count) instead of stalling; FLUSH waits for fifo_ready.
module saxo_capture_ctl #(
    parameter int DIV_W  = 16,
    parameter int LEN_W  = 24,
    parameter int DROP_W = 16
) (
    input  logic              FIFO_clk,
    input  logic              reset,
    input  logic [7:0]        probe_sync,
    input  logic              arm,
    input  logic              abort,
    input  logic [7:0]        trig_mask,
    input  logic [7:0]        trig_value,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic [LEN_W-1:0]  capture_len,
    input  logic              fifo_ready,
    output logic              fifo_wr,
    output logic              fifo_pktend,
    output logic [7:0]        fifo_dataout,
    output logic              busy,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               fifo_wr_q, fifo_wr_d;
    logic               fifo_pktend_q, fifo_pktend_d;
    logic [7:0]         fifo_dataout_q, fifo_dataout_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_count_q, drop_count_d;

    logic div_run;
    logic tick;
    logic take_sample;

`ifdef CAPTURE_TRIGGER_EN
    logic trig_hit;
    assign trig_hit = (((probe_sync ^ trig_value) & trig_mask) == 8'h00);
`else
    logic unused_trig;
    assign unused_trig = ^{trig_mask, trig_value};
`endif

    assign div_run = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign tick    = div_run && (div_q == '0);

    always_comb begin
        state_d        = state_q;
        div_d          = div_q;
        remaining_d    = remaining_q;
        fifo_wr_d      = 1'b0;
        fifo_pktend_d  = 1'b0;
        fifo_dataout_d = fifo_dataout_q;
        overflow_d     = overflow_q;
        drop_count_d   = drop_count_q;
        take_sample    = 1'b0;

        if (div_run) begin
            div_d = tick ? sample_div : (div_q - 1'b1);
        end

        case (state_q)
            ST_IDLE: begin
                if (arm && !abort) begin
                    remaining_d  = capture_len;
                    overflow_d   = 1'b0;
                    drop_count_d = '0;
                    div_d        = sample_div;
`ifdef CAPTURE_TRIGGER_EN
                    state_d      = ST_ARMED;
`else
                    state_d      = ST_CAPTURE;
`endif
                end
            end
`ifdef CAPTURE_TRIGGER_EN
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && trig_hit) begin
                    // The triggering sample is the first sample of the run.
                    take_sample = 1'b1;
                    state_d     = ST_CAPTURE;
                end
            end
`endif
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_FLUSH;
                end else if (tick) begin
                    take_sample = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fifo_ready) begin
                    fifo_pktend_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_sample) begin
            if (fifo_ready) begin
                fifo_wr_d      = 1'b1;
                fifo_dataout_d = probe_sync;
            end else begin
                overflow_d = 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + 1'b1;
                end
            end
            // A latched length of zero never counts down, giving a continuous run.
            if (remaining_q != '0) begin
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == LEN_W'(1)) begin
                    state_d = ST_FLUSH;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            div_q          <= '0;
            remaining_q    <= '0;
            fifo_wr_q      <= 1'b0;
            fifo_pktend_q  <= 1'b0;
            fifo_dataout_q <= 8'h00;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            remaining_q    <= remaining_d;
            fifo_wr_q      <= fifo_wr_d;
            fifo_pktend_q  <= fifo_pktend_d;
            fifo_dataout_q <= fifo_dataout_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign fifo_wr      = fifo_wr_q;
    assign fifo_pktend  = fifo_pktend_q;
    assign fifo_dataout = fifo_dataout_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_saxo_capture_ctl.sv
// Bench for saxo_capture_ctl: run-level reference model checked every cycle, plus literal per-scenario expectations.
`timescale 1ns/1ps
module tb_saxo_capture_ctl;

    localparam int DIV_W  = 16;
    localparam int LEN_W  = 24;
    localparam int DROP_W = 16;

    logic              FIFO_clk = 1'b0;
    logic              reset    = 1'b1;
    logic [7:0]        probe_sync = 8'h00;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        trig_mask = 8'h00;
    logic [7:0]        trig_value = 8'h00;
    logic [DIV_W-1:0]  sample_div = '0;
    logic [LEN_W-1:0]  capture_len = '0;
    logic              fifo_ready = 1'b1;
    logic              fifo_wr;
    logic              fifo_pktend;
    logic [7:0]        fifo_dataout;
    logic              busy;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic [1:0]        state;

    always #5 FIFO_clk = ~FIFO_clk;

    saxo_capture_ctl #(.DIV_W(DIV_W), .LEN_W(LEN_W), .DROP_W(DROP_W)) dut (
        .FIFO_clk(FIFO_clk), .reset(reset), .probe_sync(probe_sync), .arm(arm),
        .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
        .sample_div(sample_div), .capture_len(capture_len), .fifo_ready(fifo_ready),
        .fifo_wr(fifo_wr), .fifo_pktend(fifo_pktend), .fifo_dataout(fifo_dataout),
        .busy(busy), .overflow(overflow), .drop_count(drop_count), .state(state)
    );

`ifdef CAPTURE_TRIGGER_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. Phase: 0 idle, 1 waiting for trigger, 2 capturing, 3 flushing.
    int         m_phase = 0;
    int         m_since = 0;
    int         m_period = 0;
    int         m_left = 0;
    bit         m_endless = 1'b0;
    logic       e_wr = 1'b0;
    logic       e_pkt = 1'b0;
    logic [7:0] e_dat = 8'h00;
    logic       e_ovf = 1'b0;
    int         e_drop = 0;

    always @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_since = 0; m_period = 0; m_left = 0; m_endless = 1'b0;
            e_wr = 1'b0; e_pkt = 1'b0; e_dat = 8'h00; e_ovf = 1'b0; e_drop = 0;
        end else begin
            e_wr  = 1'b0;
            e_pkt = 1'b0;
            if (m_phase == 0) begin
                if (arm && !abort) begin
                    m_left    = int'(capture_len);
                    m_endless = (capture_len == 0);
                    m_period  = int'(sample_div);
                    m_since   = 0;
                    e_ovf     = 1'b0;
                    e_drop    = 0;
                    m_phase   = TRIG ? 1 : 2;
                end
            end else if (m_phase == 3) begin
                if (fifo_ready) begin
                    e_pkt   = 1'b1;
                    m_phase = 0;
                end
            end else if (abort) begin
                m_phase = (m_phase == 1) ? 0 : 3;
            end else if (m_since == m_period) begin
                m_since = 0;
                if (m_phase == 2 || ((probe_sync & trig_mask) == (trig_value & trig_mask))) begin
                    m_phase = 2;
                    if (fifo_ready) begin
                        e_wr  = 1'b1;
                        e_dat = probe_sync;
                    end else begin
                        e_ovf = 1'b1;
                        if (e_drop < 65535) e_drop++;
                    end
                    if (!m_endless) begin
                        m_left--;
                        if (m_left == 0) m_phase = 3;
                    end
                end
            end else begin
                m_since++;
            end
        end
    end

    bit         chk_en = 1'b0;
    int         cyc_n = 0;
    logic [7:0] got_q[$];
    int         wr_t[$];
    int         got_pkt = 0;

    always @(negedge FIFO_clk) begin
        cyc_n++;
        if (chk_en) begin
            chk("wr", fifo_wr, e_wr);
            chk("pktend", fifo_pktend, e_pkt);
            chk("dataout", fifo_dataout, e_dat);
            chk("busy", busy, (m_phase != 0));
            chk("overflow", overflow, e_ovf);
            chk("drop_count", drop_count, e_drop);
            chk("state", state, m_phase);
            if (fifo_wr === 1'b1) begin
                got_q.push_back(fifo_dataout);
                wr_t.push_back(cyc_n);
            end
            if (fifo_pktend === 1'b1) got_pkt++;
        end
    end

    bit ramp = 1'b0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge FIFO_clk);
            if (ramp) probe_sync = probe_sync + 8'd1;
        end
    endtask

    task automatic clr();
        got_q.delete();
        wr_t.delete();
        got_pkt = 0;
    endtask

    task automatic start_run(input logic [7:0] p0);
        probe_sync = p0;
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge FIFO_clk);
        chk_en = 1'b1;
        chk("rst_state", state, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr", fifo_wr, 1'b0);
        chk("rst_dat", fifo_dataout, 8'h00);
        chk("rst_drop", drop_count, 16'd0);
        reset = 1'b0;
        cyc(2);

        // Four back-to-back writes of a ramp, then one pktend.
        clr(); sample_div = 0; capture_len = 4; fifo_ready = 1'b1; ramp = 1'b1;
        start_run(8'h0F);
        cyc(12);
        chk("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t1_data", (i < got_q.size()) ? got_q[i] : 8'hEE, 8'h10 + i);
        if (wr_t.size() == 4) chk("t1_back2back", wr_t[3] - wr_t[0], 3);
        chk("t1_pkt", got_pkt, 1);
        chk("t1_state", state, 2'd0);
        chk("t1_ovf", overflow, 1'b0);

        // Divide by three: writes every third cycle.
        clr(); sample_div = 2; capture_len = 3;
        start_run(8'h20);
        cyc(20);
        chk("t2_count", got_q.size(), 3);
        chk("t2_first", (got_q.size() > 0) ? got_q[0] : 8'hEE, 8'h23);
        if (wr_t.size() == 3) begin
            chk("t2_gap1", wr_t[1] - wr_t[0], 3);
            chk("t2_gap2", wr_t[2] - wr_t[1], 3);
        end
        chk("t2_pkt", got_pkt, 1);

        // Masked trigger on bit 7.
        clr(); ramp = 1'b0; sample_div = 0; capture_len = 2;
        trig_mask = 8'h80; trig_value = 8'h80;
        start_run(8'h05);
        cyc(18);
        chk("t3_pre_count", got_q.size(), TRIG ? 0 : 2);
        chk("t3_pre_state", state, TRIG ? 2'd1 : 2'd0);
        probe_sync = 8'h85;
        cyc(10);
        chk("t3_count", got_q.size(), 2);
        chk("t3_first", (got_q.size() > 0) ? got_q[0] : 8'hEE, TRIG ? 8'h85 : 8'h05);
        chk("t3_pkt", got_pkt, 1);

        // Abort shortly after arm: no pktend if still waiting for the trigger.
        clr(); probe_sync = 8'h05; capture_len = 0;
        start_run(8'h05);
        cyc(3);
        abort = 1'b1; cyc(1); abort = 1'b0;
        cyc(4);
        chk("t3b_pkt", got_pkt, TRIG ? 0 : 1);
        chk("t3b_state", state, 2'd0);
        trig_mask = 8'h00; trig_value = 8'h00;

        // Five dropped samples out of ten, then FLUSH held by a full FIFO.
        clr(); ramp = 1'b1; capture_len = 10; fifo_ready = 1'b1;
        start_run(8'h40);
        cyc(2);
        fifo_ready = 1'b0; cyc(5);
        fifo_ready = 1'b1; cyc(3);
        fifo_ready = 1'b0; cyc(4);
        chk("t4_hold_state", state, 2'd3);
        chk("t4_hold_pkt", got_pkt, 0);
        fifo_ready = 1'b1; cyc(3);
        chk("t4_count", got_q.size(), 5);
        chk("t4_third", (got_q.size() > 2) ? got_q[2] : 8'hEE, 8'h48);
        chk("t4_ovf", overflow, 1'b1);
        chk("t4_drop", drop_count, 16'd5);
        chk("t4_pkt", got_pkt, 1);

        // Single-sample run.
        clr(); capture_len = 1;
        start_run(8'h60);
        cyc(6);
        chk("t5_count", got_q.size(), 1);
        chk("t5_data", (got_q.size() > 0) ? got_q[0] : 8'hEE, 8'h61);
        chk("t5_pkt", got_pkt, 1);

        // Continuous run ended by abort.
        clr(); capture_len = 0;
        start_run(8'h00);
        cyc(999);
        abort = 1'b1; cyc(1); abort = 1'b0;
        cyc(5);
        chk("t6_count_ok", (got_q.size() >= 999 && got_q.size() <= 1001), 1'b1);
        chk("t6_pkt", got_pkt, 1);
        chk("t6_state", state, 2'd0);

        // arm and abort together in IDLE do nothing.
        clr(); arm = 1'b1; abort = 1'b1; cyc(3);
        arm = 1'b0; abort = 1'b0; cyc(2);
        chk("t7_state", state, 2'd0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_count", got_q.size(), 0);

        // Reset during a run with drops pending.
        clr(); capture_len = 0; fifo_ready = 1'b0;
        start_run(8'h70);
        cyc(6);
        chk("t8_pre_ovf", overflow, 1'b1);
        chk("t8_pre_state", state, 2'd2);
        #2 reset = 1'b1;
        #1;
        chk("t8_rst_wr", fifo_wr, 1'b0);
        chk("t8_rst_pkt", fifo_pktend, 1'b0);
        chk("t8_rst_dat", fifo_dataout, 8'h00);
        chk("t8_rst_busy", busy, 1'b0);
        chk("t8_rst_ovf", overflow, 1'b0);
        chk("t8_rst_drop", drop_count, 16'd0);
        chk("t8_rst_state", state, 2'd0);
        cyc(2);
        reset = 1'b0; fifo_ready = 1'b1;
        cyc(4);
        chk("t8_pkt", got_pkt, 0);
        chk("t8_state", state, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
